// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for the bit-serial adder.
// master drives operands and done_ready; slave returns result and status.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    output start_valid, a_in, b_in, cin, done_ready,
    input  start_ready, sum_out, cout, done_valid, busy
  );

  modport slave (
    input  start_valid, a_in, b_in, cin, done_ready,
    output start_ready, sum_out, cout, done_valid, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add.
// Ports: clk, rst_n (async active-low), bus (serial_adder_if.slave).
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fs;
  logic             fc;
  logic             accept;
  logic             run;
  logic             last;

  assign accept = bus.start_valid && (state == IDLE);
  assign run    = (state == RUN);
  assign last   = (cnt == CW'(WIDTH - 1));

  fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fs),
    .co (fc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start_valid) state_nx = RUN;
      RUN:     if (last)            state_nx = DONE;
      DONE:    if (bus.done_ready)  state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          a_sh  <= bus.a_in;
          b_sh  <= bus.b_in;
          carry <= bus.cin;
          cnt   <= '0;
        end
        run: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= {fs, r_sh[WIDTH-1:1]};
          carry <= fc;
          cnt   <= cnt + CW'(1);
          // final bit: publish the assembled word and last carry
          if (last) begin
            sum_q  <= {fs, r_sh[WIDTH-1:1]};
            cout_q <= fc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done_valid  = (state == DONE);
  assign bus.sum_out     = sum_q;
  assign bus.cout        = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8).
// Driver queues expected sums; a monitor pops on each done_valid rise.
module tb_serial_adder;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  serial_adder_if #(.WIDTH(W)) sa_if ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sa_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input bit hold, input bit scramble,
                      output int acc);
    int n;
    logic [W:0] full;
    @(negedge clk);
    sa_if.start_valid = 1'b1;
    sa_if.a_in = a;
    sa_if.b_in = b;
    sa_if.cin = c;
    n = 0;
    while (!sa_if.start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sa_if.start_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no start_ready expected 1");
      sa_if.start_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    sb.push_back('{s: full[W-1:0], c: full[W], acc: acc});
    if (!hold) sa_if.start_valid = 1'b0;
    if (scramble) begin
      repeat (W) begin
        @(negedge clk);
        sa_if.a_in = W'($urandom);
        sa_if.b_in = W'($urandom);
        sa_if.cin  = 1'($urandom);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !sa_if.start_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // monitor: result check on each done_valid rise, stability otherwise
  initial begin
    logic         prev_dv;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    exp_t         e;
    prev_dv = 1'b0;
    prev_sum = '0;
    prev_cout = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sa_if.done_valid && !prev_dv) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got sum %0h expected none",
                     sa_if.sum_out);
          end else begin
            e = sb.pop_front();
            chk("sum", 32'(sa_if.sum_out), 32'(e.s));
            chk("cout", 32'(sa_if.cout), 32'(e.c));
            chk("latency", 32'(cyc - e.acc), 32'(W));
          end
        end else if (sa_if.sum_out !== prev_sum ||
                     sa_if.cout !== prev_cout) begin
          n_cmp++;
          n_bad++;
          $display("FAIL result_stable: got %0h/%0b expected %0h/%0b",
                   sa_if.sum_out, sa_if.cout, prev_sum, prev_cout);
        end
      end
      prev_dv = rst_n ? sa_if.done_valid : 1'b0;
      prev_sum = sa_if.sum_out;
      prev_cout = sa_if.cout;
    end
  end

  initial begin
    int acc1;
    int acc2;
    logic [W:0] f;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    sa_if.start_valid = 1'b0;
    sa_if.a_in = '0;
    sa_if.b_in = '0;
    sa_if.cin = 1'b0;
    sa_if.done_ready = 1'b1;
    #1;
    chk("rst_sum", 32'(sa_if.sum_out), 0);
    chk("rst_cout", 32'(sa_if.cout), 0);
    chk("rst_done", 32'(sa_if.done_valid), 0);
    chk("rst_busy", 32'(sa_if.busy), 0);
    chk("rst_ready", 32'(sa_if.start_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(8'h3C, 8'h0F, 1'b0, 0, 0, acc1);
    wait_idle();
    send(8'hFF, 8'h01, 1'b0, 0, 0, acc1);
    wait_idle();
    send(8'hFF, 8'hFF, 1'b1, 0, 0, acc1);
    wait_idle();

    // consumer stall in DONE
    sa_if.done_ready = 1'b0;
    send(8'h12, 8'h34, 1'b1, 0, 0, acc1);
    begin
      int n;
      n = 0;
      while (!sa_if.done_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_done", 32'(sa_if.done_valid), 1);
      chk("stall_busy", 32'(sa_if.busy), 1);
      chk("stall_sum", 32'(sa_if.sum_out), 32'h47);
      chk("stall_cout", 32'(sa_if.cout), 0);
    end
    sa_if.done_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_done", 32'(sa_if.done_valid), 0);
    chk("release_ready", 32'(sa_if.start_ready), 1);
    chk("release_busy", 32'(sa_if.busy), 0);

    // abort mid-RUN
    send(8'h55, 8'hAA, 1'b1, 0, 0, acc1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sa_if.sum_out), 0);
    chk("abort_cout", 32'(sa_if.cout), 0);
    chk("abort_done", 32'(sa_if.done_valid), 0);
    chk("abort_busy", 32'(sa_if.busy), 0);
    chk("abort_ready", 32'(sa_if.start_ready), 1);
    sb.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // start_valid held through RUN and DONE
    send(8'h3C, 8'h0F, 1'b0, 1, 0, acc1);
    send(8'hFF, 8'h01, 1'b0, 0, 0, acc2);
    chk("b2b_accept", 32'(acc2), 32'(acc1 + W + 2));
    wait_idle();

    // operand churn during RUN
    repeat (4) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 0, 1, acc1);
      wait_idle();
    end

    // random traffic
    repeat (40) begin
      ra = W'($urandom);
      rb = W'($urandom);
      f = {1'b0, ra} + {1'b0, rb};
      send(ra, rb, 1'($urandom), 0, f[0], acc1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
